aes_core_iter: RTL and testbench

//  Iterative AES block cipher core, one round per clock, for AES-128/192/256 via parameter NK.

---
 rtl/aes_pkg.sv | 141 ++++++++++++++
 rtl/aes_round.sv | 38 +++
 rtl/aes_core_iter.sv | 104 ++++++++++
 tb/tb_aes_core_iter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES shared types, S-box tables and round transforms.
// Inverse tables/functions exist only when AES_DECRYPT_EN is defined.
package aes_pkg;

    // Byte (col c, row r) lives at s[3-c][3-r], so byte 0 is bits [127:120]
    typedef logic [3:0][3:0][7:0] aes_state_t;
    typedef logic [127:0] aes_key_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } fsm_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_lu(input logic [7:0] a);
        return SBOX[2047 - 8 * int'(a) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_state_t sub_bytes(input aes_state_t s);
        aes_state_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[c][r] = sbox_lu(s[c][r]);
        return o;
    endfunction

    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[3-c][3-r] = s[3-((c+r)%4)][3-r];
        return o;
    endfunction

    function automatic aes_state_t mix_columns(input aes_state_t s);
        aes_state_t o;
        logic [7:0] a [4];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++)
                a[r] = s[3-c][3-r];
            for (int r = 0; r < 4; r++)
                o[3-c][3-r] = xtime(a[r]) ^ xtime(a[(r+1)%4])
                            ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
        return o;
    endfunction

`ifdef AES_DECRYPT_EN
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox_lu(input logic [7:0] a);
        return INV_SBOX[2047 - 8 * int'(a) -: 8];
    endfunction

    // GF(2^8) multiply by a 4-bit constant (9, 11, 13, 14)
    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [3:0] m);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int k = 0; k < 4; k++) begin
            if (m[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic aes_state_t inv_sub_bytes(input aes_state_t s);
        aes_state_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[c][r] = inv_sbox_lu(s[c][r]);
        return o;
    endfunction

    function automatic aes_state_t inv_shift_rows(input aes_state_t s);
        aes_state_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[3-((c+r)%4)][3-r] = s[3-c][3-r];
        return o;
    endfunction

    function automatic aes_state_t inv_mix_columns(input aes_state_t s);
        aes_state_t o;
        logic [7:0] a [4];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++)
                a[r] = s[3-c][3-r];
            for (int r = 0; r < 4; r++)
                o[3-c][3-r] = gmul(a[r], 4'd14)
                            ^ gmul(a[(r+1)%4], 4'd11)
                            ^ gmul(a[(r+2)%4], 4'd13)
                            ^ gmul(a[(r+3)%4], 4'd9);
        end
        return o;
    endfunction
`endif

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: st, key, decrypt, final_rnd -> nxt.
// Inverse path built only with AES_DECRYPT_EN defined.
module aes_round
    import aes_pkg::*;
(
    input  aes_state_t st,
    input  aes_key_t   key,
    input  logic       decrypt,
    input  logic       final_rnd,
    output aes_state_t nxt
);

    aes_state_t enc_t;
    aes_state_t enc_o;

    always_comb begin
        enc_t = shift_rows(sub_bytes(st));
        enc_o = (final_rnd ? enc_t : mix_columns(enc_t)) ^ key;
    end

`ifdef AES_DECRYPT_EN
    aes_state_t dec_t;
    aes_state_t dec_o;

    // Key is added before InvMixColumns (straight inverse cipher order)
    always_comb begin
        dec_t = inv_sub_bytes(inv_shift_rows(st)) ^ key;
        dec_o = final_rnd ? dec_t : inv_mix_columns(dec_t);
    end

    assign nxt = decrypt ? dec_o : enc_o;
`else
    logic unused_dec;
    assign unused_dec = decrypt;
    assign nxt = enc_o;
`endif

endmodule

// File: rtl/aes_core_iter.sv
// Iterative AES-128/192/256 core, one round per clock, valid/ready both sides.
// Ports: clk, rst_n, k_sch, abort, in_*, out_*, busy. Option: AES_DECRYPT_EN.
module aes_core_iter
    import aes_pkg::*;
#(
    parameter  int NK = 4,
    localparam int NR = NK + 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NR:0][127:0]    k_sch,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          in_data,
    input  logic                  in_decrypt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          out_data,
    output logic                  busy
);

    localparam int RW = $clog2(NR + 1);
    localparam logic [RW-1:0] NR_R = RW'(NR);

    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
        $error("aes_core_iter: NK must be 4, 6 or 8");
    end

    fsm_t          state;
    fsm_t          state_d;
    logic [RW-1:0] rnd;
    logic [RW-1:0] kidx;
    aes_state_t    st;
    aes_state_t    st_nxt;
    aes_key_t      key0;
    logic          mode_dec;
    logic          acc;
    logic          last;

    assign acc       = in_valid & in_ready;
    assign last      = (rnd == NR_R);
    assign in_ready  = (state == S_IDLE) | ((state == S_DONE) & out_ready);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign out_data  = st;

`ifdef AES_DECRYPT_EN
    always_ff @(posedge clk)
        if (acc && !abort) mode_dec <= in_decrypt;

    assign kidx = mode_dec ? NR_R - rnd : rnd;
    assign key0 = in_decrypt ? k_sch[NR] : k_sch[0];
`else
    logic unused_dec;
    assign unused_dec = in_decrypt;
    assign mode_dec   = 1'b0;
    assign kidx       = rnd;
    assign key0       = k_sch[0];
`endif

    aes_round u_round (
        .st        (st),
        .key       (k_sch[kidx]),
        .decrypt   (mode_dec),
        .final_rnd (last),
        .nxt       (st_nxt)
    );

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE: if (acc) state_d = S_RUN;
            S_RUN:  if (last) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = in_valid ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            rnd   <= '0;
        end else begin
            state <= state_d;
            if (abort)
                rnd <= '0;
            else if (acc)
                rnd <= RW'(1);
            else if (state == S_RUN && !last)
                rnd <= rnd + RW'(1);
        end
    end

    // Datapath state is deliberately left unreset
    always_ff @(posedge clk) begin
        if (acc && !abort)
            st <= in_data ^ key0;
        else if (state == S_RUN)
            st <= st_nxt;
    end

endmodule

// File: tb/tb_aes_core_iter.sv
// Directed bench for aes_core_iter: NK=4/6/8 instances, known-answer
// vectors, stall, back-to-back, abort and reset corner sequences.
module tb_aes_core_iter;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic iv [3];
    logic dec [3];
    logic ab [3];
    logic ordy [3];
    logic ir [3];
    logic ov [3];
    logic bz [3];
    logic [127:0] idata [3];
    logic [127:0] od [3];
    logic [14:0][127:0] ks [3];

    int n_cmp = 0;
    int n_bad = 0;

    aes_core_iter #(.NK(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .k_sch(ks[0][10:0]), .abort(ab[0]),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idata[0]),
        .in_decrypt(dec[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_data(od[0]), .busy(bz[0])
    );

    aes_core_iter #(.NK(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .k_sch(ks[1][12:0]), .abort(ab[1]),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idata[1]),
        .in_decrypt(dec[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_data(od[1]), .busy(bz[1])
    );

    aes_core_iter #(.NK(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .k_sch(ks[2]), .abort(ab[2]),
        .in_valid(iv[2]), .in_ready(ir[2]), .in_data(idata[2]),
        .in_decrypt(dec[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_data(od[2]), .busy(bz[2])
    );

    typedef struct packed {
        logic [1:0]   j;
        logic         dec;
        logic [255:0] key;
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    localparam logic [255:0] K128 =
        {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192 =
        {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KNIST =
        {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sbox_lu(t[31:24]), sbox_lu(t[23:16]),
                sbox_lu(t[15:8]), sbox_lu(t[7:0])};
    endfunction

    function automatic logic [14:0][127:0] expand(input logic [255:0] key,
                                                  input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0] rc;
        logic [14:0][127:0] o;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        o = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++)
            o[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return o;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out", nm);
    endtask

    // Returns at the falling edge right after the accepting rising edge
    task automatic send(input int j, input logic [127:0] d, input logic de);
        int n;
        @(negedge clk);
        iv[j] = 1'b1;
        idata[j] = d;
        dec[j] = de;
        n = 0;
        while (!ir[j] && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!ir[j]) timeout("send");
        @(negedge clk);
        iv[j] = 1'b0;
        dec[j] = 1'b0;
    endtask

    // lat counts rising edges from the accepting edge to out_valid seen
    task automatic wait_out(input int j, output int lat,
                            output logic [127:0] d);
        lat = 1;
        while (!ov[j] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!ov[j]) timeout("wait_out");
        d = od[j];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tv [$];
        vec_t v;
        int lat;
        int nin;
        int nout;
        int acc_c [3];
        logic [127:0] d;
        logic [127:0] pts [4];
        logic [127:0] cts [4];

        pts[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
        pts[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        pts[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
        pts[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
        cts[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        cts[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
        cts[2] = 128'h43b1cd7f598ece23881b00e3ed030688;
        cts[3] = 128'h7b0c785e27e8ad3f8223207104725dd4;

        tv.push_back('{2'd0, 1'b0, K128, PT0, CT4});
        tv.push_back('{2'd1, 1'b0, K192, PT0,
                       128'hdda97ca4864cdfe06eaf70a0ec0d7191});
        tv.push_back('{2'd2, 1'b0, K256, PT0,
                       128'h8ea2b7ca516745bfeafc49904b496089});
        tv.push_back('{2'd0, 1'b0, KNIST,
                       128'h3243f6a8885a308d313198a2e0370734,
                       128'h3925841d02dc09fbdc118597196a0b32});
`ifdef AES_DECRYPT_EN
        tv.push_back('{2'd0, 1'b1, K128, CT4, PT0});
        tv.push_back('{2'd0, 1'b1, KNIST,
                       128'h3925841d02dc09fbdc118597196a0b32,
                       128'h3243f6a8885a308d313198a2e0370734});
`else
        tv.push_back('{2'd0, 1'b1, K128, PT0, CT4});
`endif

        rst_n = 1'b0;
        for (int j = 0; j < 3; j++) begin
            iv[j] = 1'b0;
            dec[j] = 1'b0;
            ab[j] = 1'b0;
            ordy[j] = 1'b1;
            idata[j] = '0;
            ks[j] = '0;
        end
        repeat (2) @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            chk1($sformatf("rst_in_ready%0d", j), ir[j], 1'b1);
            chk1($sformatf("rst_out_valid%0d", j), ov[j], 1'b0);
            chk1($sformatf("rst_busy%0d", j), bz[j], 1'b0);
        end
        rst_n = 1'b1;

        foreach (tv[k]) begin
            v = tv[k];
            ks[int'(v.j)] = expand(v.key, 4 + 2 * int'(v.j));
            send(int'(v.j), v.din, v.dec);
            wait_out(int'(v.j), lat, d);
            chk($sformatf("vec%0d_data", k), d, v.dout);
            chk($sformatf("vec%0d_lat", k), 128'(lat),
                128'(11 + 2 * int'(v.j)));
        end

        // Hold the result for 20 cycles with out_ready low
        @(negedge clk);
        ks[0] = expand(K128, 4);
        ordy[0] = 1'b0;
        send(0, PT0, 1'b0);
        wait_out(0, lat, d);
        chk("stall_first", d, CT4);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk1("stall_out_valid", ov[0], 1'b1);
            chk1("stall_in_ready", ir[0], 1'b0);
            chk("stall_data", od[0], CT4);
        end

        // Release and stream three blocks back to back
        ks[0] = expand(KNIST, 4);
        ordy[0] = 1'b1;
        #1;
        nin = 0;
        nout = 0;
        for (int c = 0; c < 100 && nout < 3; c++) begin
            if (c > 0 && ov[0]) begin
                chk($sformatf("b2b_data%0d", nout), od[0], cts[nout]);
                nout++;
            end
            if (nin < 3) begin
                iv[0] = 1'b1;
                idata[0] = pts[nin];
                if (ir[0]) begin
                    acc_c[nin] = c;
                    nin++;
                end
            end else begin
                iv[0] = 1'b0;
            end
            @(negedge clk);
            #1;
        end
        iv[0] = 1'b0;
        if (nout < 3) timeout("b2b");
        chk("b2b_first_acc", 128'(acc_c[0]), 128'(0));
        chk("b2b_gap01", 128'(acc_c[1] - acc_c[0]), 128'(11));
        chk("b2b_gap12", 128'(acc_c[2] - acc_c[1]), 128'(11));

        // Abort at round 5
        send(0, pts[0], 1'b0);
        repeat (4) @(negedge clk);
        ab[0] = 1'b1;
        @(negedge clk);
        ab[0] = 1'b0;
        chk1("abort_out_valid", ov[0], 1'b0);
        chk1("abort_busy", bz[0], 1'b0);
        chk1("abort_in_ready", ir[0], 1'b1);
        repeat (15) @(negedge clk);
        chk1("abort_dropped", ov[0], 1'b0);
        send(0, pts[1], 1'b0);
        wait_out(0, lat, d);
        chk("after_abort_data", d, cts[1]);
        chk("after_abort_lat", 128'(lat), 128'(11));

        // Abort beats a simultaneous accept
        @(negedge clk);
        iv[0] = 1'b1;
        idata[0] = pts[2];
        ab[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        ab[0] = 1'b0;
        chk1("abort_vs_acc_busy", bz[0], 1'b0);

        // Reset pulse at round 5
        send(0, pts[2], 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk1("rstmid_out_valid", ov[0], 1'b0);
        chk1("rstmid_busy", bz[0], 1'b0);
        chk1("rstmid_in_ready", ir[0], 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        send(0, pts[3], 1'b0);
        wait_out(0, lat, d);
        chk("after_rst_data", d, cts[3]);
        chk("after_rst_lat", 128'(lat), 128'(11));

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
